ifetch_unit: RTL and testbench

Instruction fetch stage feeding the single-cycle `CPU` core. It holds the program counter and fetches one instruction per step from an external instruction memory over a req/ack handshake. It presents the instruction (`inst`, mirrored by the core as `test_inst`) until the core signals retirement, then applies the core's next-PC decision: sequential, branch, jump or register jump. A missing memory response raises a sticky fetch error.

---
 rtl/ifetch_unit.sv | 137 +++++++++++++
 tb/tb_ifetch_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over a req/ack handshake,
// holds the instruction until retirement and applies the core's next-PC choice.
module ifetch_unit #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          ACK_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] inst,
   output logic        inst_valid,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   input  logic        inst_done,
   input  logic        branch_taken,
   input  logic [31:0] branch_offset,
   input  logic        jump,
   input  logic [25:0] jump_target,
   input  logic        jr,
   input  logic [31:0] jr_addr,
   output logic        fetch_err
);

   localparam int               CNT_W    = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_VALID = 2'd2,
      ST_ERR   = 2'd3
   } state_t;

   state_t           state_r, state_nxt_s;
   logic [31:0]      pc_r, pc_nxt_s;
   logic [31:0]      inst_r, inst_nxt_s;
   logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
   logic [31:0]      pc_plus4_s;

   // Redirect priority: register jump, then absolute jump, then branch, then fall-through.
   function automatic logic [31:0] next_pc(
      input logic [31:0] seq_pc,
      input logic        do_jr,
      input logic [31:0] jr_tgt,
      input logic        do_jump,
      input logic [25:0] jump_idx,
      input logic        do_branch,
      input logic [31:0] offset
   );
      logic [31:0] res;
      if (do_jr) begin
         res = jr_tgt & 32'hFFFF_FFFC;
      end else if (do_jump) begin
         res = {seq_pc[31:28], jump_idx, 2'b00};
      end else if (do_branch) begin
         res = seq_pc + (offset << 5'd2);
      end else begin
         res = seq_pc;
      end
      return res;
   endfunction

   assign pc_plus4_s = pc_r + 32'd4;

   // Next-state, next-PC, instruction latch and ack-timeout counter.
   always_comb begin
      state_nxt_s = state_r;
      pc_nxt_s    = pc_r;
      inst_nxt_s  = inst_r;
      cnt_nxt_s   = cnt_r;
      case (state_r)
         ST_IDLE: begin
            state_nxt_s = ST_REQ;
         end
         ST_REQ: begin
            if (imem_ack) begin
               inst_nxt_s  = imem_rdata;
               cnt_nxt_s   = {CNT_W{1'b0}};
               state_nxt_s = ST_VALID;
            end else if (cnt_r == CNT_LAST) begin
               inst_nxt_s  = 32'd0;
               cnt_nxt_s   = {CNT_W{1'b0}};
               state_nxt_s = ST_ERR;
            end else begin
               cnt_nxt_s   = cnt_r + CNT_ONE;
            end
         end
         ST_VALID: begin
            if (inst_done) begin
               pc_nxt_s    = next_pc(pc_plus4_s, jr, jr_addr, jump, jump_target,
                                     branch_taken, branch_offset);
               state_nxt_s = ST_REQ;
            end else begin
               state_nxt_s = ST_VALID;
            end
         end
         ST_ERR: begin
            inst_nxt_s  = 32'd0;
            state_nxt_s = ST_ERR;
         end
         default: begin
            state_nxt_s = ST_IDLE;
            pc_nxt_s    = RESET_PC;
            inst_nxt_s  = 32'd0;
            cnt_nxt_s   = {CNT_W{1'b0}};
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= ST_IDLE;
         pc_r    <= RESET_PC;
         inst_r  <= 32'd0;
         cnt_r   <= {CNT_W{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         pc_r    <= pc_nxt_s;
         inst_r  <= inst_nxt_s;
         cnt_r   <= cnt_nxt_s;
      end
   end

   assign imem_req   = (state_r == ST_REQ);
   assign inst_valid = (state_r == ST_VALID);
   assign fetch_err  = (state_r == ST_ERR);
   assign imem_addr  = pc_r;
   assign pc         = pc_r;
   assign pc_plus4   = pc_plus4_s;
   assign inst       = inst_r;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed-plus-random bench for ifetch_unit against a next-PC reference model
// written directly from the fetch/redirect rules.
module tb_ifetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = 32'd0;
   logic [31:0] inst;
   logic        inst_valid;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        inst_done = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_offset = 32'd0;
   logic        jump = 1'b0;
   logic [25:0] jump_target = 26'd0;
   logic        jr = 1'b0;
   logic [31:0] jr_addr = 32'd0;
   logic        fetch_err;

   int          chk_cnt  = 0;
   int          pass_cnt = 0;
   logic [31:0] m_pc     = 32'd0;
   logic [31:0] m_inst   = 32'd0;
   logic [31:0] w;
   logic        r_jr, r_j, r_b;

   ifetch_unit #(.RESET_PC(32'h0000_0000), .ACK_TIMEOUT(16)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .inst(inst), .inst_valid(inst_valid),
      .pc(pc), .pc_plus4(pc_plus4),
      .inst_done(inst_done), .branch_taken(branch_taken),
      .branch_offset(branch_offset), .jump(jump), .jump_target(jump_target),
      .jr(jr), .jr_addr(jr_addr), .fetch_err(fetch_err)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed no completion, expected finish before 500000");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Entered at a negedge inside REQ; ack after 'waits' empty cycles.
   task automatic fetch(input int waits, input logic [31:0] word);
      check("req_on", {31'd0, imem_req}, 32'd1);
      check("addr", imem_addr, m_pc);
      for (int i = 0; i < waits; i++) begin
         imem_ack   = 1'b0;
         imem_rdata = $urandom;
         inst_done  = 1'($urandom);
         jr         = 1'($urandom);
         jr_addr    = $urandom;
         @(negedge clk);
         check("req_hold", {31'd0, imem_req}, 32'd1);
         check("addr_hold", imem_addr, m_pc);
         check("valid_low_wait", {31'd0, inst_valid}, 32'd0);
      end
      imem_ack   = 1'b1;
      imem_rdata = word;
      inst_done  = 1'($urandom);
      @(negedge clk);
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      inst_done  = 1'b0;
      jr         = 1'b0;
      m_inst     = word;
      check("inst_valid", {31'd0, inst_valid}, 32'd1);
      check("inst", inst, word);
      check("req_off", {31'd0, imem_req}, 32'd0);
      check("pc", pc, m_pc);
      check("pc_plus4", pc_plus4, m_pc + 32'd4);
   endtask

   // Entered at a negedge inside VALID; holds, then retires with the given redirect.
   task automatic retire(input int hold, input logic j_r, input logic [31:0] j_addr,
                         input logic j, input logic [25:0] tgt,
                         input logic b, input logic [31:0] off);
      logic [31:0] seq;
      for (int i = 0; i < hold; i++) begin
         inst_done    = 1'b0;
         jr           = 1'($urandom);
         jump         = 1'($urandom);
         branch_taken = 1'($urandom);
         @(negedge clk);
         check("inst_stable", inst, m_inst);
         check("valid_hold", {31'd0, inst_valid}, 32'd1);
      end
      inst_done     = 1'b1;
      jr            = j_r;
      jr_addr       = j_addr;
      jump          = j;
      jump_target   = tgt;
      branch_taken  = b;
      branch_offset = off;
      seq = m_pc + 32'd4;
      if (j_r)    m_pc = j_addr - (j_addr % 32'd4);
      else if (j) m_pc = (seq & 32'hF000_0000) + 32'(tgt) * 32'd4;
      else if (b) m_pc = seq + off * 32'd4;
      else        m_pc = seq;
      @(negedge clk);
      inst_done    = 1'b0;
      jr           = 1'b0;
      jump         = 1'b0;
      branch_taken = 1'b0;
      check("valid_fall", {31'd0, inst_valid}, 32'd0);
      check("req_rise", {31'd0, imem_req}, 32'd1);
      check("next_pc", pc, m_pc);
      check("next_addr", imem_addr, m_pc);
   endtask

   initial begin
      // Reset state
      @(negedge clk);
      check("rst_req", {31'd0, imem_req}, 32'd0);
      check("rst_valid", {31'd0, inst_valid}, 32'd0);
      check("rst_err", {31'd0, fetch_err}, 32'd0);
      check("rst_inst", inst, 32'd0);
      check("rst_pc", pc, 32'h0000_0000);
      rst  = 1'b1;
      m_pc = 32'h0000_0000;
      @(negedge clk);

      // Sequential fetch 0x0 -> 0x10
      for (int i = 0; i < 4; i++) begin
         fetch(0, $urandom);
         retire(0, 1'b0, 32'd0, 1'b0, 26'd0, 1'b0, 32'd0);
      end
      check("seq_pc_0x10", pc, 32'h0000_0010);

      // Branches
      fetch(1, $urandom);
      retire(1, 1'b0, 32'd0, 1'b0, 26'd0, 1'b1, 32'hFFFF_FFFE);
      check("branch_back", pc, 32'h0000_000C);
      fetch(0, $urandom);
      retire(0, 1'b0, 32'd0, 1'b0, 26'd0, 1'b0, 32'd0);
      fetch(2, $urandom);
      retire(0, 1'b0, 32'd0, 1'b0, 26'd0, 1'b1, 32'd3);
      check("branch_fwd", pc, 32'h0000_0020);

      // Jump and priority
      fetch(0, $urandom);
      retire(0, 1'b1, 32'h1000_0002, 1'b0, 26'd0, 1'b0, 32'd0);
      check("jr_align", pc, 32'h1000_0000);
      fetch(0, $urandom);
      retire(0, 1'b0, 32'd0, 1'b1, 26'h3FF_FFFF, 1'b0, 32'd0);
      check("jump", pc, 32'h1FFF_FFFC);
      fetch(0, $urandom);
      retire(0, 1'b1, 32'h1000_0000, 1'b0, 26'd0, 1'b0, 32'd0);
      fetch(0, $urandom);
      retire(0, 1'b1, 32'h0000_4003, 1'b1, 26'($urandom), 1'b1, $urandom);
      check("priority", pc, 32'h0000_4000);

      // Wait states, last-chance ack, and wrap
      fetch(3, $urandom);
      retire(0, 1'b1, 32'hFFFF_FFFF, 1'b0, 26'd0, 1'b0, 32'd0);
      fetch(15, $urandom);
      retire(0, 1'b0, 32'd0, 1'b0, 26'd0, 1'b0, 32'd0);
      check("wrap", pc, 32'h0000_0000);

      // Randomized redirects
      for (int i = 0; i < 24; i++) begin
         fetch($urandom_range(0, 6), $urandom);
         r_jr = ($urandom_range(0, 3) == 0);
         r_j  = ($urandom_range(0, 3) == 0);
         r_b  = ($urandom_range(0, 2) == 0);
         retire($urandom_range(0, 2), r_jr, $urandom, r_j, 26'($urandom), r_b, $urandom);
      end

      // Reset mid-fetch at pc 0x8
      fetch(0, $urandom);
      retire(0, 1'b1, 32'h0000_0008, 1'b0, 26'd0, 1'b0, 32'd0);
      imem_ack = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("mid_rst_req", {31'd0, imem_req}, 32'd0);
      check("mid_rst_valid", {31'd0, inst_valid}, 32'd0);
      check("mid_rst_pc", pc, 32'h0000_0000);
      check("mid_rst_inst", inst, 32'd0);
      @(negedge clk);
      rst  = 1'b1;
      m_pc = 32'h0000_0000;
      @(negedge clk);
      check("restart_req", {31'd0, imem_req}, 32'd1);
      check("restart_addr", imem_addr, 32'h0000_0000);

      // Timeout after 16 REQ cycles
      w = $urandom | 32'h1;
      fetch(0, w);
      retire(0, 1'b0, 32'd0, 1'b0, 26'd0, 1'b0, 32'd0);
      for (int i = 0; i < 15; i++) begin
         imem_ack = 1'b0;
         @(negedge clk);
         check("to_req_hold", {31'd0, imem_req}, 32'd1);
         check("to_no_err", {31'd0, fetch_err}, 32'd0);
      end
      @(negedge clk);
      check("to_err", {31'd0, fetch_err}, 32'd1);
      check("to_req_off", {31'd0, imem_req}, 32'd0);
      check("to_inst_nop", inst, 32'd0);
      check("to_valid", {31'd0, inst_valid}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         imem_ack   = 1'b1;
         imem_rdata = $urandom;
         inst_done  = 1'b1;
         jr         = 1'b1;
         @(negedge clk);
         check("err_sticky", {31'd0, fetch_err}, 32'd1);
         check("err_inst", inst, 32'd0);
      end
      imem_ack  = 1'b0;
      inst_done = 1'b0;
      jr        = 1'b0;
      rst = 1'b0;
      #1;
      check("err_clear", {31'd0, fetch_err}, 32'd0);
      @(negedge clk);
      rst  = 1'b1;
      m_pc = 32'h0000_0000;
      @(negedge clk);
      fetch(0, $urandom);
      retire(0, 1'b0, 32'd0, 1'b0, 26'd0, 1'b0, 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
